// File: rtl/kernel_cc_fifo_srl_param.sv
// kernel_cc_fifo_srl_param
// Shift-register FIFO for HLS dataflow streams. New data enters SRL[0] and
// older entries shift up; the head sits at SRL[count-1]. Occupancy, all
// status flags and the sticky error bits are registered and derived from the
// next-state count, so no request input reaches an output combinationally.
module kernel_cc_fifo_srl_param #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 1,
  parameter int CNT_WIDTH  = 2,
  parameter int AF_LEVEL   = 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic [CNT_WIDTH-1:0]  if_num_data_valid,
  output logic                  if_almost_full_n,
  output logic                  if_almost_empty_n,
  output logic                  if_err_ovf,
  output logic                  if_err_udf
);

  logic [DATA_WIDTH-1:0] r_srl [DEPTH];
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_empty_n;
  logic                  r_full_n;
  logic                  r_almost_full_n;
  logic                  r_almost_empty_n;
  logic                  r_err_ovf;
  logic                  r_err_udf;

  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_dout;

  // Gated requests; accept decisions use only the registered flags.
  assign w_wr_req = if_write & if_write_ce;
  assign w_rd_req = if_read  & if_read_ce;
  assign w_wr_ok  = w_wr_req & r_full_n;
  assign w_rd_ok  = w_rd_req & r_empty_n;

  // Next occupancy: simultaneous accepted push and pop cancel out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr_ok && !w_rd_ok)      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    else if (w_rd_ok && !w_wr_ok) w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
  end

  // Head address; an empty FIFO points at SRL[0] so the output is never X-indexed.
  assign w_rd_addr = (r_cnt == '0) ? '0 : ADDR_WIDTH'(r_cnt - CNT_WIDTH'(1));

  // Read mux written as a compare loop so non-power-of-two depths never index past the array.
  always_comb begin
    w_dout = r_srl[0];
    for (int i = 1; i < DEPTH; i++)
      if (w_rd_addr == ADDR_WIDTH'(i)) w_dout = r_srl[i];
  end

  // Shift storage; contents are deliberately not reset (count governs validity).
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_srl[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) r_srl[i] <= r_srl[i-1];
    end
  end

  // Count and flags update together from the next-state count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt            <= '0;
      r_empty_n        <= 1'b0;
      r_full_n         <= 1'b1;
      r_almost_full_n  <= 1'b1;
      r_almost_empty_n <= 1'b0;
    end else begin
      r_cnt            <= w_cnt_nxt;
      r_empty_n        <= (w_cnt_nxt != '0);
      r_full_n         <= (w_cnt_nxt != CNT_WIDTH'(DEPTH));
      r_almost_full_n  <= (w_cnt_nxt <  CNT_WIDTH'(AF_LEVEL));
      r_almost_empty_n <= (w_cnt_nxt >  CNT_WIDTH'(AE_LEVEL));
    end
  end

  // Sticky error bits: set on a gated request the FIFO cannot honour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if (w_wr_req && !r_full_n)  r_err_ovf <= 1'b1;
      if (w_rd_req && !r_empty_n) r_err_udf <= 1'b1;
    end
  end

  assign if_dout           = w_dout;
  assign if_empty_n        = r_empty_n;
  assign if_full_n         = r_full_n;
  assign if_num_data_valid = r_cnt;
  assign if_almost_full_n  = r_almost_full_n;
  assign if_almost_empty_n = r_almost_empty_n;
  assign if_err_ovf        = r_err_ovf;
  assign if_err_udf        = r_err_udf;

endmodule

// File: tb/tb_kernel_cc_fifo_srl_param.sv
// Directed bench for kernel_cc_fifo_srl_param, DEPTH=5, AF=4, AE=1.
module tb_kernel_cc_fifo_srl_param;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_empty_n, if_full_n, if_almost_full_n, if_almost_empty_n;
  logic          if_err_ovf, if_err_udf;
  logic          if_read_ce, if_read, if_write_ce, if_write;
  logic [DW-1:0] if_din, if_dout;
  logic [2:0]    if_num_data_valid;

  int checks = 0;
  int errors = 0;

  kernel_cc_fifo_srl_param #(
    .DATA_WIDTH(DW), .DEPTH(5), .ADDR_WIDTH(3), .CNT_WIDTH(3),
    .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .reset(reset),
    .if_empty_n(if_empty_n), .if_read_ce(if_read_ce), .if_read(if_read),
    .if_dout(if_dout), .if_full_n(if_full_n), .if_write_ce(if_write_ce),
    .if_write(if_write), .if_din(if_din), .if_num_data_valid(if_num_data_valid),
    .if_almost_full_n(if_almost_full_n), .if_almost_empty_n(if_almost_empty_n),
    .if_err_ovf(if_err_ovf), .if_err_udf(if_err_udf)
  );

  always #5 clk = ~clk;

  // One clock with the given request pattern; returns #1 after the edge.
  task automatic cyc(input logic wr, input logic wce, input logic [DW-1:0] d,
                     input logic rd, input logic rce);
    if_write = wr; if_write_ce = wce; if_din = d;
    if_read = rd;  if_read_ce = rce;
    @(posedge clk); #1;
    if_write = 1'b0; if_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({if_num_data_valid, if_empty_n, if_full_n, if_almost_full_n, if_almost_empty_n,
         if_err_ovf, if_err_udf} !== {3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d en=%b fn=%b afn=%b aen=%b ovf=%b udf=%b",
               if_num_data_valid, if_empty_n, if_full_n, if_almost_full_n,
               if_almost_empty_n, if_err_ovf, if_err_udf);
    end
  endtask

  // T1: fill with A1..A5 then drain in order.
  task automatic test_fill_drain();
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 1'b1, DW'(16'hA0 + k), 1'b0, 1'b1);
      checks++;
      if (if_num_data_valid !== 3'(k) || if_empty_n !== 1'b1 ||
          if_almost_full_n !== (k < 4) || if_almost_empty_n !== (k > 1) ||
          if_full_n !== (k != 5) || if_dout !== 16'hA1) begin
        errors++;
        $display("FAIL fill_%0d: cnt=%0d fn=%b afn=%b aen=%b dout=%h", k,
                 if_num_data_valid, if_full_n, if_almost_full_n, if_almost_empty_n, if_dout);
      end
    end
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (if_dout !== DW'(16'hA0 + k)) begin
        errors++;
        $display("FAIL drain_dout_%0d: got %h want %h", k, if_dout, 16'hA0 + k);
      end
      cyc(1'b0, 1'b1, '0, 1'b1, 1'b1);
      checks++;
      if (if_num_data_valid !== 3'(5 - k) || if_empty_n !== (k != 5) || if_full_n !== 1'b1) begin
        errors++;
        $display("FAIL drain_cnt_%0d: cnt=%0d en=%b fn=%b", k, if_num_data_valid,
                 if_empty_n, if_full_n);
      end
    end
  endtask

  // T2: full, write B6 plus read -> only the read happens.
  task automatic test_full_wr_rd();
    for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b1, DW'(16'hA0 + k), 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 16'hB6, 1'b1, 1'b1);
    checks++;
    if (if_num_data_valid !== 3'd4 || if_dout !== 16'hA2 || if_err_ovf !== 1'b1 ||
        if_full_n !== 1'b1 || if_err_udf !== 1'b0) begin
      errors++;
      $display("FAIL full_wr_rd: cnt=%0d dout=%h ovf=%b udf=%b fn=%b (want 4 a2 1 0 1)",
               if_num_data_valid, if_dout, if_err_ovf, if_err_udf, if_full_n);
    end
  endtask

  // T3: empty, write C1 plus read -> only the write happens.
  task automatic test_empty_wr_rd();
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, '0, 1'b1, 1'b1);
    checks++;
    if (if_empty_n !== 1'b0 || if_num_data_valid !== 3'd0) begin
      errors++;
      $display("FAIL empty_pre: en=%b cnt=%0d", if_empty_n, if_num_data_valid);
    end
    cyc(1'b1, 1'b1, 16'hC1, 1'b1, 1'b1);
    checks++;
    if (if_num_data_valid !== 3'd1 || if_dout !== 16'hC1 || if_err_udf !== 1'b1 ||
        if_err_ovf !== 1'b1 || if_empty_n !== 1'b1) begin
      errors++;
      $display("FAIL empty_wr_rd: cnt=%0d dout=%h udf=%b ovf=%b (want 1 c1 1 1)",
               if_num_data_valid, if_dout, if_err_udf, if_err_ovf);
    end
  endtask

  // T4: steady state at count=3, push+pop each cycle.
  task automatic test_back_to_back();
    logic [DW-1:0] q[$];
    q.push_back(16'hC1);
    cyc(1'b1, 1'b1, 16'hD1, 1'b0, 1'b1); q.push_back(16'hD1);
    cyc(1'b1, 1'b1, 16'hD2, 1'b0, 1'b1); q.push_back(16'hD2);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (if_dout !== q[0] || if_num_data_valid !== 3'd3) begin
        errors++;
        $display("FAIL b2b_%0d: dout=%h want %h cnt=%0d want 3", i, if_dout, q[0],
                 if_num_data_valid);
      end
      cyc(1'b1, 1'b1, DW'(16'hE00 + i), 1'b1, 1'b1);
      void'(q.pop_front());
      q.push_back(DW'(16'hE00 + i));
    end
    checks++;
    if (if_dout !== 16'hE11 || if_num_data_valid !== 3'd3) begin
      errors++;
      $display("FAIL b2b_end: dout=%h want e11 cnt=%0d", if_dout, if_num_data_valid);
    end
  endtask

  // T5: CE low makes requests inert, including error capture.
  task automatic test_ce_gating();
    do_reset();
    for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b1, DW'(16'hF0 + k), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 16'hDEAD, 1'b1, 1'b0);
    checks++;
    if (if_num_data_valid !== 3'd5 || if_dout !== 16'hF1 || if_err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ce_full: cnt=%0d dout=%h ovf=%b (want 5 f1 0)",
               if_num_data_valid, if_dout, if_err_ovf);
    end
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, '0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (if_num_data_valid !== 3'd0 || if_empty_n !== 1'b0 || if_err_udf !== 1'b0 ||
        if_err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ce_empty: cnt=%0d en=%b udf=%b ovf=%b", if_num_data_valid,
               if_empty_n, if_err_udf, if_err_ovf);
    end
  endtask

  // T6: asynchronous reset mid-cycle with four entries held.
  task automatic test_async_reset();
    for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b1, DW'(16'h50 + k), 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 16'h99, 1'b1, 1'b1); // push+pop keeps an error-free state
    checks++;
    if (if_num_data_valid !== 3'd4 || if_almost_full_n !== 1'b0) begin
      errors++;
      $display("FAIL arst_pre: cnt=%0d afn=%b", if_num_data_valid, if_almost_full_n);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({if_num_data_valid, if_empty_n, if_full_n, if_almost_full_n, if_almost_empty_n,
         if_err_ovf, if_err_udf} !== {3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL arst_async: cnt=%0d en=%b fn=%b afn=%b aen=%b", if_num_data_valid,
               if_empty_n, if_full_n, if_almost_full_n, if_almost_empty_n);
    end
    @(posedge clk); #1 reset = 1'b0;
    cyc(1'b0, 1'b1, '0, 1'b0, 1'b1);
    checks++;
    if (if_num_data_valid !== 3'd0 || if_empty_n !== 1'b0) begin
      errors++;
      $display("FAIL arst_after: cnt=%0d en=%b", if_num_data_valid, if_empty_n);
    end
    cyc(1'b1, 1'b1, 16'h77, 1'b0, 1'b1);
    checks++;
    if (if_dout !== 16'h77 || if_num_data_valid !== 3'd1) begin
      errors++;
      $display("FAIL arst_fresh: dout=%h cnt=%0d", if_dout, if_num_data_valid);
    end
  endtask

  initial begin
    reset = 1'b0;
    if_read = 1'b0; if_read_ce = 1'b1;
    if_write = 1'b0; if_write_ce = 1'b1;
    if_din = '0;
    #2;
    test_reset();
    test_fill_drain();
    test_full_wr_rd();
    test_empty_wr_rd();
    test_back_to_back();
    test_ce_gating();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
